rr_grant_responder: RTL and testbench
=====================================

Name: rr_grant_responder

Overview:
- Grant-side responder for the single-cycle req/gnt handshake used across the codebase: it arbitrates up to N requesters and drives a registered one-hot grant.
- Guarantees the protocol rule: a requester whose req rises while the arbiter is idle sees its gnt rise exactly one clock later.
- Sits between bus initiators and a shared resource.
- Adds round-robin fairness and a bounded hold time, with preemption when the hold limit is reached.

Parameters:
- N, 4: number of requesters (≥2).
- MAX_HOLD, 16: maximum consecutive cycles a single grant may stay high (≥2).

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  N  per-requester request level; held high while access is wanted.
- gnt  out  N  registered one-hot (or zero) grant.
- gnt_id  out  $clog2(N)  index of the current owner; valid while busy=1.
- busy  out  1  high when any gnt bit is high.
- preempt  out  1  one-cycle pulse on the cycle after a grant is removed by hold-limit timeout.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - gnt=0, gnt_id=0, busy=0, preempt=0.
  - Round-robin pointer ptr=0, hold counter cnt=0, block mask blk=0.
  - gnt drops immediately, even mid-grant. No outputs change until the first clk edge after rst_n rises.
- Eligibility: eligible = req & ~blk.
- Selection: the first eligible index scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
- State IDLE (busy=0):
  - If eligible≠0 at a clk edge, then at that edge: gnt=onehot(sel), gnt_id=sel, cnt=1, go GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
- State GRANT, owner o, evaluated at each edge:
  - (a) req[o]=0: release. ptr=o+1 mod N.
    - If another index is eligible (o excluded), hand over in the same edge: gnt switches directly to onehot(sel), cnt=1. No idle cycle.
    - Otherwise gnt=0 and go IDLE.
  - (b) req[o]=1 and cnt<MAX_HOLD: hold. cnt=cnt+1.
  - (c) req[o]=1 and cnt==MAX_HOLD: preempt.
    - blk[o]=1, ptr=o+1, preempt=1 for that following cycle.
    - Hand over to an eligible requester if any, else gnt=0 and go IDLE.
    - gnt[o] is therefore high for exactly MAX_HOLD cycles.
- Block clear: blk[i] clears at any edge where req[i]=0. A blocked requester must drop req for ≥1 sampled cycle before it can be granted again.
- Simultaneous events:
  - req[o] falling at the same edge the hold limit is reached follows rule (a): no preempt, blk unchanged.
  - A new req rising while another owner holds the grant waits. Its gnt rises one cycle after the edge at which it is selected.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[i]=1 implies req[i] was 1 at the granting edge.
  - busy = |gnt, registered.
  - cnt saturates and never exceeds MAX_HOLD. Width is $clog2(MAX_HOLD+1).
- preempt defaults to 0 every cycle unless set by rule (c).

Test Plan:
- Reset then single request: req=4'b0001 from edge 10 → gnt=4'b0001 from edge 11, busy=1, gnt_id=0. req dropped at edge 14 → gnt=0 at edge 15.
- Round robin: all of req=4'b1111 held, each owner drops req 3 cycles after its grant and reasserts 1 cycle later → grant order 0,1,2,3,0 with direct handover and no idle cycle.
- Timeout: MAX_HOLD=16, req[2] held high forever → gnt[2] high exactly 16 cycles. Then preempt=1 for 1 cycle and gnt=0. gnt[2] is never reasserted until req[2] goes low ≥1 cycle and rises again, after which gnt[2] rises 1 cycle later.
- Preempt with waiter: req[1] held, req[3] rises mid-hold → at the preempt edge gnt switches 4'b0010→4'b1000 and preempt=1 in the same cycle.
- Simultaneous release/timeout: req[0] drops exactly at the edge where cnt==16 → gnt=0, preempt stays 0, req[0] re-granted 1 cycle after its next rise.
- Async reset mid-grant: rst_n pulled low between edges while gnt=4'b0100 → gnt=0, busy=0 immediately. After release, the first grant goes to the lowest-index requester (ptr=0).

Source files
------------

// File: rtl/rr_grant_responder.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_responder
//  Purpose  : Round-robin req/gnt responder with one-cycle grant latency,
//             bounded hold time and hold-limit preemption.
//  Revision : 1.0  initial release
// ============================================================================
module rr_grant_responder #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 preempt
);

    localparam int                c_W       = $clog2(N);
    localparam int                c_CW      = $clog2(MAX_HOLD + 1);
    localparam logic [c_CW-1:0]   c_MAX     = c_CW'(MAX_HOLD);
    localparam logic [c_CW-1:0]   c_CNT_ONE = c_CW'(1);
    localparam logic [N-1:0]      c_ONE     = N'(1);
    localparam logic [c_W-1:0]    c_LAST    = c_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [c_W-1:0]  r_gnt_id;
    logic            r_busy;
    logic            r_preempt;
    logic [c_W-1:0]  r_ptr;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_blk;

    logic [N-1:0]    w_own_mask;
    logic            w_own_req;
    logic [c_W-1:0]  w_ptr_inc;
    logic [c_W-1:0]  w_base;
    logic [N-1:0]    w_elig;
    logic            w_sel_valid;
    logic [c_W-1:0]  w_sel;
    int              w_idx;

    // While granted, the scan starts just past the owner and skips it, so a
    // release or preemption hands over fairly in the same edge.
    always_comb begin
        w_own_mask = c_ONE << r_gnt_id;
        w_own_req  = |(req & w_own_mask);
        w_ptr_inc  = (r_gnt_id == c_LAST) ? '0 : r_gnt_id + c_W'(1);
        if (r_state == ST_GRANT) begin
            w_base = w_ptr_inc;
            w_elig = req & ~r_blk & ~w_own_mask;
        end else begin
            w_base = r_ptr;
            w_elig = req & ~r_blk;
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        w_idx       = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(w_base) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_sel_valid && w_elig[w_idx]) begin
                w_sel_valid = 1'b1;
                w_sel       = c_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_blk     <= '0;
        end else begin
            r_preempt <= 1'b0;
            r_blk     <= r_blk & req;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_gnt    <= c_ONE << w_sel;
                        r_gnt_id <= w_sel;
                        r_busy   <= 1'b1;
                        r_cnt    <= c_CNT_ONE;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_own_req || (r_cnt == c_MAX)) begin
                        r_ptr <= w_ptr_inc;
                        // Owner still requesting here means the hold limit expired.
                        if (w_own_req) begin
                            r_blk     <= (r_blk & req) | w_own_mask;
                            r_preempt <= 1'b1;
                        end
                        if (w_sel_valid) begin
                            r_gnt    <= c_ONE << w_sel;
                            r_gnt_id <= w_sel;
                            r_cnt    <= c_CNT_ONE;
                        end else begin
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_grant_responder
//  Purpose  : Directed self-checking bench for rr_grant_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_grant_responder;

    localparam int c_N        = 4;
    localparam int c_MAX_HOLD = 16;

    logic           clk;
    logic           rst_n;
    logic [c_N-1:0] req;
    logic [c_N-1:0] gnt;
    logic [1:0]     gnt_id;
    logic           busy;
    logic           preempt;

    int total;
    int bad;
    int owner;

    rr_grant_responder #(
        .N        (c_N),
        .MAX_HOLD (c_MAX_HOLD)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        check_eq("rst_gnt",     32'(gnt),     32'h0);
        check_eq("rst_busy",    32'(busy),    32'h0);
        check_eq("rst_gnt_id",  32'(gnt_id),  32'h0);
        check_eq("rst_preempt", 32'(preempt), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("idle_noreq", 32'(gnt), 32'h0);

        // single request: one-cycle latency, release to idle
        req = 4'b0001;
        check_eq("t1_pre", 32'(gnt), 32'h0);
        step();
        check_eq("t1_gnt",  32'(gnt),    32'h1);
        check_eq("t1_busy", 32'(busy),   32'h1);
        check_eq("t1_id",   32'(gnt_id), 32'h0);
        repeat (3) step();
        check_eq("t1_hold", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        check_eq("t1_rel_gnt",  32'(gnt),  32'h0);
        check_eq("t1_rel_busy", 32'(busy), 32'h0);

        // round robin with direct handover
        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            owner = i % 4;
            check_eq("rr_gnt",  32'(gnt),    32'(1) << owner);
            check_eq("rr_busy", 32'(busy),   32'h1);
            check_eq("rr_id",   32'(gnt_id), 32'(owner));
            if (i < 4) begin
                step();
                step();
                check_eq("rr_hold", 32'(gnt), 32'(1) << owner);
                req[owner] = 1'b0;
                step();
                req[owner] = 1'b1;
            end
        end
        req = 4'b0000;
        step();
        check_eq("rr_end_gnt",  32'(gnt),  32'h0);
        check_eq("rr_end_busy", 32'(busy), 32'h0);

        // hold-limit timeout with no waiter, then block until req drops
        do_reset();
        req = 4'b0100;
        step();
        check_eq("to_gnt", 32'(gnt), 32'h4);
        for (int i = 0; i < c_MAX_HOLD - 1; i++) begin
            step();
            check_eq("to_hold",   32'(gnt),     32'h4);
            check_eq("to_nopre",  32'(preempt), 32'h0);
        end
        step();
        check_eq("to_cut_gnt",  32'(gnt),     32'h0);
        check_eq("to_cut_pre",  32'(preempt), 32'h1);
        check_eq("to_cut_busy", 32'(busy),    32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("to_blk_gnt", 32'(gnt),     32'h0);
            check_eq("to_blk_pre", 32'(preempt), 32'h0);
        end
        req = 4'b0000;
        step();
        check_eq("to_drop_gnt", 32'(gnt), 32'h0);
        req = 4'b0100;
        step();
        check_eq("to_regnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        step();

        // preemption with a waiter: handover and pulse in the same cycle
        do_reset();
        req = 4'b0010;
        step();
        check_eq("pw_gnt", 32'(gnt), 32'h2);
        repeat (5) step();
        req = 4'b1010;
        repeat (10) step();
        check_eq("pw_hold",  32'(gnt),     32'h2);
        check_eq("pw_nopre", 32'(preempt), 32'h0);
        step();
        check_eq("pw_sw_gnt", 32'(gnt),     32'h8);
        check_eq("pw_sw_pre", 32'(preempt), 32'h1);
        check_eq("pw_sw_id",  32'(gnt_id),  32'h3);
        step();
        check_eq("pw_after_gnt", 32'(gnt),     32'h8);
        check_eq("pw_after_pre", 32'(preempt), 32'h0);
        req = 4'b0000;
        step();
        check_eq("pw_end_gnt", 32'(gnt), 32'h0);

        // release coinciding with hold limit: no preemption
        do_reset();
        req = 4'b0001;
        step();
        repeat (c_MAX_HOLD - 1) step();
        check_eq("sim_hold", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        check_eq("sim_gnt",  32'(gnt),     32'h0);
        check_eq("sim_pre",  32'(preempt), 32'h0);
        check_eq("sim_busy", 32'(busy),    32'h0);
        step();
        check_eq("sim_pre2", 32'(preempt), 32'h0);
        req = 4'b0001;
        step();
        check_eq("sim_regnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();

        // asynchronous reset mid-grant with pointer advanced
        do_reset();
        req = 4'b0010;
        step();
        check_eq("ar_gnt1", 32'(gnt), 32'h2);
        req = 4'b0100;
        step();
        check_eq("ar_gnt2", 32'(gnt), 32'h4);
        step();
        check_eq("ar_hold", 32'(gnt), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_gnt",  32'(gnt),    32'h0);
        check_eq("ar_busy", 32'(busy),   32'h0);
        check_eq("ar_id",   32'(gnt_id), 32'h0);
        req = 4'b1111;
        step();
        check_eq("ar_inrst", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("ar_first_gnt", 32'(gnt),    32'h1);
        check_eq("ar_first_id",  32'(gnt_id), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
